cache_mem_sequencer: RTL and testbench



---
 rtl/mem_seq_pkg.sv | 26 ++
 rtl/mem_req_fifo.sv | 62 ++++++
 rtl/cache_mem_sequencer.sv | 157 +++++++++++++++
 tb/tb_cache_mem_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the cache-to-DDR2 request sequencer: FSM states and the
// queued request entry.
package mem_seq_pkg;

  localparam int unsigned SEQ_ADDR_W = 31;
  localparam int unsigned SEQ_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_WR = 2'd1,
    ISSUE_RD = 2'd2,
    WAIT_RD  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                  we;
    logic [SEQ_ADDR_W-1:0] addr;
    logic [SEQ_LINE_W-1:0] data;
  } req_entry_t;

  // Burst-4 alignment: the two low address bits are always dropped.
  function automatic logic [SEQ_ADDR_W-1:0] burst_align(input logic [SEQ_ADDR_W-1:0] a);
    return a & ~SEQ_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request queue with full/empty flags and a registered head entry
// so the consumer never sees a memory-read path at pop time.
module mem_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_ptr_nx = rd_ptr + PTR_W'(1);
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nx;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // Head tracks the oldest entry; a push into an empty (or emptying) queue bypasses memory.
      if (do_pop) begin
        if (count == CNT_W'(1)) head <= push_data;
        else                    head <= mem[rd_ptr_nx];
      end else if (empty && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/cache_mem_sequencer.sv
// Sequences queued whole-line cache requests onto the DDR2 interface handshake,
// one command outstanding at a time, and returns read lines or timeout errors.
module cache_mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned APPDATA_WIDTH    = SEQ_LINE_W / 2,
  parameter int unsigned INPUT_ADDR_WIDTH = SEQ_ADDR_W,
  parameter int unsigned QDEPTH           = 4,
  parameter int unsigned RD_TIMEOUT       = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          phy_init_done,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [INPUT_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*APPDATA_WIDTH-1:0]    req_data,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic [2*APPDATA_WIDTH-1:0]    rsp_data,
  input  logic                          mc_wr_rdy,
  input  logic                          mc_rd_rdy,
  input  logic                          mc_rd_valid,
  input  logic [2*APPDATA_WIDTH-1:0]    data_rd,
  output logic                          data_wren,
  output logic                          data_rden,
  output logic [INPUT_ADDR_WIDTH-1:0]   data_addr,
  output logic [2*APPDATA_WIDTH-1:0]    data_wr,
  output logic                          busy,
  output logic                          misalign,
  output logic                          stray_rd
);

  localparam int unsigned LINE_W  = 2 * APPDATA_WIDTH;
  localparam int unsigned TMR_W   = $clog2(RD_TIMEOUT);
  localparam int unsigned ENTRY_W = $bits(req_entry_t);
  // Compare one early so the registered error response lands RD_TIMEOUT cycles after data_rden.
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(RD_TIMEOUT - 2);

  req_entry_t                  push_entry;
  req_entry_t                  head_entry;
  logic [ENTRY_W-1:0]          head_bits;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  seq_state_t                  state;
  seq_state_t                  state_d;
  logic [TMR_W-1:0]            timer;
  logic [TMR_W-1:0]            timer_d;
  logic [INPUT_ADDR_WIDTH-1:0] addr_d;
  logic [LINE_W-1:0]           wr_d;
  logic [LINE_W-1:0]           rsp_data_d;
  logic                        rsp_valid_d;
  logic                        rsp_err_d;

  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign busy       = !fifo_empty || (state != IDLE);
  assign head_entry = req_entry_t'(head_bits);

  always_comb begin
    push_entry.we   = req_we;
    push_entry.addr = burst_align(SEQ_ADDR_W'(req_addr));
    push_entry.data = SEQ_LINE_W'(req_data);
  end

  mem_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bits)
  );

  // Next-state, command strobes and response capture.
  always_comb begin
    state_d     = state;
    timer_d     = timer;
    addr_d      = data_addr;
    wr_d        = data_wr;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data;
    pop         = 1'b0;
    data_wren   = 1'b0;
    data_rden   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && phy_init_done) begin
          pop     = 1'b1;
          addr_d  = INPUT_ADDR_WIDTH'(head_entry.addr);
          wr_d    = LINE_W'(head_entry.data);
          state_d = head_entry.we ? ISSUE_WR : ISSUE_RD;
        end
      end
      ISSUE_WR: begin
        data_wren = mc_wr_rdy;
        if (mc_wr_rdy) state_d = IDLE;
      end
      ISSUE_RD: begin
        data_rden = mc_rd_rdy;
        if (mc_rd_rdy) begin
          timer_d = '0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mc_rd_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_rd;
          state_d     = IDLE;
        end else if (timer == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = IDLE;
        end else if (timer != '1) begin
          timer_d = timer + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      data_addr <= '0;
      data_wr   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      misalign  <= 1'b0;
      stray_rd  <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      data_addr <= addr_d;
      data_wr   <= wr_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
      if (push && (req_addr[1:0] != 2'b00)) misalign <= 1'b1;
      if (mc_rd_valid && (state != WAIT_RD)) stray_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_mem_sequencer.sv
// Scoreboard bench for cache_mem_sequencer: transaction-level expectations for
// commands and read responses, checked by an independent monitor.
module tb_cache_mem_sequencer;

  localparam int unsigned AW = 31;
  localparam int unsigned DW = 256;
  localparam int          R  = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          phy_init_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;
  logic          mc_wr_rdy;
  logic          mc_rd_rdy;
  logic          mc_rd_valid;
  logic [DW-1:0] data_rd;
  logic          data_wren;
  logic          data_rden;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wr;
  logic          busy;
  logic          misalign;
  logic          stray_rd;

  always #5 clk = ~clk;

  cache_mem_sequencer #(
    .APPDATA_WIDTH    (DW / 2),
    .INPUT_ADDR_WIDTH (AW),
    .QDEPTH           (4),
    .RD_TIMEOUT       (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .phy_init_done (phy_init_done),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_data      (rsp_data),
    .mc_wr_rdy     (mc_wr_rdy),
    .mc_rd_rdy     (mc_rd_rdy),
    .mc_rd_valid   (mc_rd_valid),
    .data_rd       (data_rd),
    .data_wren     (data_wren),
    .data_rden     (data_rden),
    .data_addr     (data_addr),
    .data_wr       (data_wr),
    .busy          (busy),
    .misalign      (misalign),
    .stray_rd      (stray_rd)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Memory-side model controls
  int            next_delay = 7;
  bit            rand_delay = 1'b0;
  bit            fixed_en   = 1'b0;
  logic [DW-1:0] fixed_line = '0;
  bit            pend       = 1'b0;
  int            fire_cyc   = 0;
  logic [DW-1:0] pend_data  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: every command strobe and every response is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    cmd_t e;
    rsp_t r;
    if (!rst) begin
      if (data_wren || data_rden) begin
        chk("strobe_exclusive", DW'(data_wren & data_rden), '0);
        chk("cmd_expected", DW'(cmd_q.size() != 0), DW'(1));
        if (cmd_q.size() != 0) begin
          e = cmd_q.pop_front();
          chk("cmd_kind_we", DW'(data_wren), DW'(e.we));
          chk("cmd_addr", DW'(data_addr), DW'(e.addr));
          if (e.we) chk("cmd_wr_data", data_wr, e.data);
        end
      end
      if (rsp_valid) begin
        chk("rsp_expected", DW'(rsp_q.size() != 0), DW'(1));
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          chk("rsp_err", DW'(rsp_err), DW'(r.err));
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_cycle", DW'(cyc), DW'(r.cyc));
        end
      end
    end
  end

  // Memory-controller read model: answers each read after a chosen delay; delays
  // of R or more mean the sequencer times out first and the answer arrives late.
  initial begin : mc_model
    int   d;
    rsp_t r;
    mc_rd_valid = 1'b0;
    data_rd     = '0;
    forever begin
      @(negedge clk);
      mc_rd_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend && cyc == fire_cyc) begin
          mc_rd_valid = 1'b1;
          data_rd     = pend_data;
          pend        = 1'b0;
        end
        if (data_rden) begin
          d         = rand_delay ? int'($urandom_range(25, 1)) : next_delay;
          pend_data = fixed_en ? fixed_line : rand_line();
          pend      = 1'b1;
          fire_cyc  = cyc + d;
          if (d < R) begin
            r.err = 1'b0; r.data = pend_data; r.cyc = cyc + d + 1;
          end else begin
            r.err = 1'b1; r.data = '0; r.cyc = cyc + R;
          end
          rsp_q.push_back(r);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      output bit acc, output int at);
    cmd_t e;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data;
    @(negedge clk);
    acc = req_ready;
    at  = cyc;
    if (acc) begin
      e.we = we; e.addr = {addr[AW-1:2], 2'b00}; e.data = data;
      cmd_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_wait(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           output int at);
    bit acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) send(we, addr, data, acc, at);
    chk("request_accepted", DW'(acc), DW'(1));
  endtask

  task automatic wait_strobe(output int at);
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_wren || data_rden) begin
        at = cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (cmd_q.size() == 0 && rsp_q.size() == 0 && !busy && !pend) done = 1'b1;
    end
    chk("drain_in_time", DW'(done), DW'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    @(negedge clk);
    chk({tag, "_req_ready"}, DW'(req_ready), DW'(1));
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
    chk({tag, "_rsp_err"}, DW'(rsp_err), '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_strobes"}, DW'({data_wren, data_rden}), '0);
    chk({tag, "_data_addr"}, DW'(data_addr), '0);
    chk({tag, "_data_wr"}, data_wr, '0);
    chk({tag, "_misalign"}, DW'(misalign), '0);
    chk({tag, "_stray_rd"}, DW'(stray_rd), '0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  n;
    int  t;
    int  m;
    int  seen;
    int  accepted;
    bit  acc;

    rst = 1'b1; phy_init_done = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_data = '0; mc_wr_rdy = 1'b0; mc_rd_rdy = 1'b0;
    step(3);
    chk_reset_outs("reset");
    rst = 1'b0;
    step(2);

    // Calibration hold-off
    mc_wr_rdy = 1'b1;
    send_wait(1'b1, AW'(32'h40), rand_line(), n);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_wren) seen++;
    end
    @(posedge clk); #1;
    chk("holdoff_no_wren", DW'(seen), '0);
    m = cyc;
    phy_init_done = 1'b1;
    wait_strobe(t);
    chk("init_release_latency", DW'(t), DW'(m + 1));
    wait_idle(50);

    // Single write latency and busy release
    send_wait(1'b1, AW'(32'h100), {32{8'hA5}}, n);
    wait_strobe(t);
    chk("wr_latency", DW'(t), DW'(n + 2));
    @(negedge clk);
    chk("busy_clear_after_wr", DW'(busy), '0);
    @(posedge clk); #1;

    // Read round trip with fixed data, answer 7 cycles after the strobe
    mc_rd_rdy  = 1'b1;
    fixed_en   = 1'b1;
    fixed_line = {8{32'hDEADBEEF}};
    next_delay = 7;
    send_wait(1'b0, AW'(32'h200), '0, n);
    wait_strobe(t);
    chk("rd_latency", DW'(t), DW'(n + 2));
    wait_idle(100);
    fixed_en = 1'b0;

    // Full queue: one entry held in ISSUE_WR plus four queued, then stall
    mc_wr_rdy = 1'b0;
    accepted  = 0;
    for (int k = 0; k < 16; k++) begin
      send(1'b1, AW'(4 * accepted), rand_line(), acc, t);
      if (acc) accepted++;
    end
    chk("full_accept_count", DW'(accepted), DW'(5));
    @(negedge clk);
    chk("full_req_ready_low", DW'(req_ready), '0);
    @(posedge clk); #1;
    mc_wr_rdy = 1'b1;
    send_wait(1'b1, AW'(32'h14), rand_line(), n);
    wait_idle(100);

    // Data arriving on the last cycle before timeout still wins
    next_delay = R - 1;
    send_wait(1'b0, AW'(32'h300), '0, n);
    wait_idle(R + 60);
    @(negedge clk);
    chk("stray_clear_before_timeout", DW'(stray_rd), '0);
    @(posedge clk); #1;

    // Timeout followed by a late answer
    next_delay = R + 5;
    send_wait(1'b0, AW'(32'h304), '0, n);
    wait_idle(R + 60);
    @(negedge clk);
    chk("stray_after_late_rd", DW'(stray_rd), DW'(1));
    @(posedge clk); #1;

    // Reset while waiting for read data: nothing may follow
    next_delay = 40;
    send_wait(1'b0, AW'(32'h400), '0, n);
    wait_strobe(t);
    step(5);
    rst = 1'b1;
    cmd_q.delete();
    rsp_q.delete();
    step(1);
    chk_reset_outs("midrd_reset");
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    @(posedge clk); #1;
    chk("no_rsp_after_reset", DW'(seen), '0);

    // Misaligned request is issued aligned and flagged
    send_wait(1'b1, AW'(32'h103), rand_line(), n);
    @(negedge clk);
    chk("misalign_set", DW'(misalign), DW'(1));
    @(posedge clk); #1;
    wait_idle(50);

    // Randomized traffic with random ready, calibration and read delays
    rand_delay = 1'b1;
    for (int k = 0; k < 80; k++) begin
      phy_init_done = ($urandom_range(7, 0) != 0);
      mc_wr_rdy     = ($urandom_range(9, 0) < 7);
      mc_rd_rdy     = ($urandom_range(9, 0) < 7);
      send(1'(($urandom & 1)), AW'($urandom), rand_line(), acc, t);
      step(int'($urandom_range(2, 0)));
    end
    phy_init_done = 1'b1;
    mc_wr_rdy     = 1'b1;
    mc_rd_rdy     = 1'b1;
    wait_idle(1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
